// File: rtl/eu_pkg.sv
// Shared constants for the execution-unit front end (prefetch queue and its byte ring).
package eu_pkg;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned DEF_DEPTH     = 6;
   localparam int unsigned DEF_WIN_BYTES = 4;
   localparam int unsigned DEF_IP_W      = 16;
endpackage

// File: rtl/byte_ring.sv
// Circular byte store: 1- or 2-byte write port, WIN_BYTES-wide read window at the read pointer.
// Pointers wrap modulo DEPTH, which need not be a power of two.
module byte_ring
   import eu_pkg::*;
#(
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned WIN_BYTES = DEF_WIN_BYTES
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              push,
   input  logic                              push_two,
   input  logic [2*BYTE_W-1:0]               push_data,
   input  logic [$clog2(WIN_BYTES+1)-1:0]    pop_n,
   output logic [BYTE_W*WIN_BYTES-1:0]       window
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

   // n never exceeds DEPTH, so one conditional subtract is enough to wrap.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PTR_W'(s);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wrap_add(rd_ptr_q, 32'(pop_n));
      if (push) wr_ptr_d = wrap_add(wr_ptr_q, push_two ? 2 : 1);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data[BYTE_W-1:0];
         if (push_two) mem_q[wrap_add(wr_ptr_q, 1)] <= push_data[2*BYTE_W-1:BYTE_W];
      end
   end

   always_comb begin
      window = '0;
      for (int unsigned i = 0; i < WIN_BYTES; i++) begin
         window[i*BYTE_W +: BYTE_W] = mem_q[wrap_add(rd_ptr_q, i)];
      end
   end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetch control, IP tracking and sticky error around a byte ring.
// Optional high-water mark on max_count when QUEUE_STATS_EN is defined.
module instr_prefetch_queue
   import eu_pkg::*;
#(
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned WIN_BYTES = DEF_WIN_BYTES,
   parameter int unsigned IP_W      = DEF_IP_W
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic [IP_W-1:0]                   flush_ip,
   output logic                              fetch_req,
   output logic [IP_W-1:0]                   fetch_ip,
   output logic [1:0]                        fetch_bytes,
   input  logic                              fill_valid,
   input  logic [2*BYTE_W-1:0]               fill_data,
   input  logic [$clog2(WIN_BYTES+1)-1:0]    pop_bytes,
   output logic [BYTE_W*WIN_BYTES-1:0]       win_data,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic [IP_W-1:0]                   exec_ip,
   output logic                              err,
   output logic [$clog2(DEPTH+1)-1:0]        max_count
);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned POP_W = $clog2(WIN_BYTES+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_q, count_d;
   logic [IP_W-1:0]  fetch_ip_q, fetch_ip_d;
   logic [IP_W-1:0]  exec_ip_q, exec_ip_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] fb_ext, cnt_after_pop;
   logic [POP_W-1:0] pop_eff;
   logic             pop_ok, fill_ok;
   logic [BYTE_W*WIN_BYTES-1:0] window;

   assign fetch_bytes = fetch_ip_q[0] ? 2'd1 : 2'd2;
   assign fb_ext      = CNT_W'(fetch_bytes);
   assign fetch_req   = ((DEPTH_C - count_q) >= fb_ext) && !flush;

   // Pop is resolved first so a fill may use the space it frees.
   always_comb begin
      pop_ok        = CNT_W'(pop_bytes) <= count_q;
      pop_eff       = pop_ok ? pop_bytes : '0;
      cnt_after_pop = count_q - CNT_W'(pop_eff);
      fill_ok       = fill_valid && ((DEPTH_C - cnt_after_pop) >= fb_ext);
      count_d       = cnt_after_pop + (fill_ok ? fb_ext : '0);
      fetch_ip_d    = fill_ok ? fetch_ip_q + IP_W'(fetch_bytes) : fetch_ip_q;
      exec_ip_d     = exec_ip_q + IP_W'(pop_eff);
      err_d         = err_q || !pop_ok || (fill_valid && !fill_ok);
      if (flush) begin
         count_d    = '0;
         fetch_ip_d = flush_ip;
         exec_ip_d  = flush_ip;
         err_d      = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         fetch_ip_q <= '0;
         exec_ip_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         fetch_ip_q <= fetch_ip_d;
         exec_ip_q  <= exec_ip_d;
         err_q      <= err_d;
      end
   end

   byte_ring #(
      .DEPTH     (DEPTH),
      .WIN_BYTES (WIN_BYTES)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (fill_ok && !flush),
      .push_two  (fetch_bytes == 2'd2),
      .push_data (fill_data),
      .pop_n     (pop_eff),
      .window    (window)
   );

   // Bytes beyond count hold stale data and are masked to zero.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(WIN_BYTES); i++) begin
         if (i < int'(count_q)) win_data[i*BYTE_W +: BYTE_W] = window[i*BYTE_W +: BYTE_W];
      end
   end

`ifdef QUEUE_STATS_EN
   logic [CNT_W-1:0] max_q;
   always_ff @(posedge clk) begin
      if (reset) max_q <= '0;
      else if (count_d > max_q) max_q <= count_d;
   end
   assign max_count = max_q;
`else
   assign max_count = '0;
`endif

   assign count    = count_q;
   assign fetch_ip = fetch_ip_q;
   assign exec_ip  = exec_ip_q;
   assign err      = err_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed plus random stimulus for instr_prefetch_queue against a byte-queue reference model.
module tb_instr_prefetch_queue;
   localparam int DEPTH = 6;
   localparam int WIN   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0, flush = 1'b0, fill_valid = 1'b0;
   logic [15:0] flush_ip = '0, fill_data = '0;
   logic [2:0]  pop_bytes = '0;
   logic        fetch_req, err;
   logic [15:0] fetch_ip, exec_ip;
   logic [1:0]  fetch_bytes;
   logic [31:0] win_data;
   logic [2:0]  count, max_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0]  mq[$];
   logic [15:0] m_fip, m_eip;
   logic        m_err;
   int          m_max;
   bit          known = 0;

   instr_prefetch_queue dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .flush_ip    (flush_ip),
      .fetch_req   (fetch_req),
      .fetch_ip    (fetch_ip),
      .fetch_bytes (fetch_bytes),
      .fill_valid  (fill_valid),
      .fill_data   (fill_data),
      .pop_bytes   (pop_bytes),
      .win_data    (win_data),
      .count       (count),
      .exec_ip     (exec_ip),
      .err         (err),
      .max_count   (max_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic fl, input logic [15:0] fip,
                       input logic fv, input logic [15:0] fd, input logic [2:0] pb);
      int fb;
      logic [31:0] w;
      reset = r; flush = fl; flush_ip = fip; fill_valid = fv; fill_data = fd; pop_bytes = pb;
      #2;
      fb = m_fip[0] ? 1 : 2;
      if (known && !r) begin
         chk("fetch_req", 64'(fetch_req), 64'((DEPTH - mq.size() >= fb) && !fl));
         chk("fetch_bytes", 64'(fetch_bytes), 64'(fb));
      end
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete(); m_fip = '0; m_eip = '0; m_err = 0; m_max = 0; known = 1;
      end else if (fl) begin
         mq.delete(); m_fip = fip; m_eip = fip;
      end else begin
         if (int'(pb) > mq.size()) m_err = 1;
         else begin
            repeat (int'(pb)) void'(mq.pop_front());
            m_eip = m_eip + 16'(pb);
         end
         if (fv) begin
            if (DEPTH - mq.size() >= fb) begin
               mq.push_back(fd[7:0]);
               if (fb == 2) mq.push_back(fd[15:8]);
               m_fip = m_fip + 16'(fb);
            end else m_err = 1;
         end
      end
`ifdef QUEUE_STATS_EN
      if (mq.size() > m_max) m_max = mq.size();
`endif
      w = '0;
      for (int i = 0; i < WIN; i++) if (i < mq.size()) w[i*8 +: 8] = mq[i];
      chk("count", 64'(count), 64'(mq.size()));
      chk("win_data", 64'(win_data), 64'(w));
      chk("fetch_ip", 64'(fetch_ip), 64'(m_fip));
      chk("exec_ip", 64'(exec_ip), 64'(m_eip));
      chk("err", 64'(err), 64'(m_err));
      chk("max_count", 64'(max_count), 64'(m_max));
   endtask

   initial begin
      // reset, then the directed scenarios
      step(1, 0, 16'h0, 1, 16'hFFFF, 3'd0);
      step(0, 0, 16'h0, 1, 16'h3412, 3'd0);
      step(0, 0, 16'h0, 1, 16'h7856, 3'd0);
      step(0, 0, 16'h0, 1, 16'hBC9A, 3'd0);
      step(0, 0, 16'h0, 1, 16'h1111, 3'd0);   // full: dropped, err
      step(0, 0, 16'h0, 1, 16'hDEF0, 3'd2);   // pop frees room for same-cycle fill
      step(0, 0, 16'h0, 0, 16'h0, 3'd4);
      step(0, 1, 16'h0101, 1, 16'h2222, 3'd1); // flush overrides pop and fill
      step(0, 0, 16'h0, 1, 16'h00AA, 3'd0);   // odd IP: single byte
      step(0, 0, 16'h0, 0, 16'h0, 3'd2);      // underflow
      step(0, 1, 16'hFFFE, 0, 16'h0, 3'd0);
      step(0, 0, 16'h0, 1, 16'h5A5A, 3'd0);   // fetch_ip wraps to 0
      step(0, 0, 16'h0, 0, 16'h0, 3'd0);
      step(1, 1, 16'h1234, 1, 16'h4321, 3'd1); // reset ignores flush/fill/pop
      step(0, 0, 16'h0, 0, 16'h0, 3'd0);
      for (int k = 0; k < 600; k++) begin
         logic [2:0] pb;
         pb = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 4))
                                          : 3'($urandom_range(0, (mq.size() < 4) ? mq.size() : 4));
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0), 16'($urandom),
              ($urandom_range(0, 9) < 6), 16'($urandom), pb);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
